// File: rtl/pipe_pkg.sv
// Shared constants and types for the decode/execute hazard and bypass logic.
// Latency names match the producer classes the scoreboard has to interlock.
package pipe_pkg;

    localparam int REG_W       = 5;
    localparam int LAT_ALU     = 1;
    localparam int LAT_LOAD    = 2;
    localparam int MAX_LAT_DEF = 4;
    localparam int LAT_DIV     = MAX_LAT_DEF;

    typedef enum logic {
        KS_IDLE = 1'b0,
        KS_KILL = 1'b1
    } kill_state_t;

endpackage

// File: rtl/bypass_mux.sv
// One source-operand bypass: picks the youngest forwarding bus that carries
// the requested register, otherwise the register-file value.
module bypass_mux
    import pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NFWD = 3
) (
    input  logic [REG_W-1:0]       src,
    input  logic [XLEN-1:0]        rf_val,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD*REG_W-1:0]  fwd_dst,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    output logic [XLEN-1:0]        opnd,
    output logic                   fwd_hit
);

    // Scanning from oldest to youngest lets the lowest-index match win.
    always_comb begin
        opnd    = rf_val;
        fwd_hit = 1'b0;
        if (src != '0) begin
            for (int i = NFWD - 1; i >= 0; i--) begin
                if (fwd_valid[i] && (fwd_dst[i*REG_W +: REG_W] == src)) begin
                    opnd    = fwd_data[i*XLEN +: XLEN];
                    fwd_hit = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_bypass_unit.sv
// Decode/execute interlock: per-register latency scoreboard, per-port operand
// bypass and a timed decode kill window after a control-flow redirect.
module hazard_bypass_unit
    import pipe_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NSRC     = 2,
    parameter int NFWD     = 3,
    parameter int MAX_LAT  = LAT_DIV,
    parameter int KILL_CYC = 2,
    localparam int LW      = $clog2(MAX_LAT + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dec_valid,
    input  logic [NSRC*REG_W-1:0]  dec_src,
    input  logic [NSRC-1:0]        dec_src_used,
    input  logic [NSRC-1:0]        dec_src_late,
    input  logic                   dec_wr,
    input  logic [REG_W-1:0]       dec_dst,
    input  logic [LW-1:0]          dec_lat,
    input  logic [NSRC*XLEN-1:0]   rf_val,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD*REG_W-1:0]  fwd_dst,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    input  logic                   redirect,
    output logic                   stall,
    output logic                   kill,
    output logic [NSRC*XLEN-1:0]   opnd,
    output logic [NSRC-1:0]        fwd_hit
);

    localparam int KW = (KILL_CYC > 1) ? $clog2(KILL_CYC) : 1;

    logic [LW-1:0]   pend [NREG];
    logic [NSRC-1:0] hazard;
    logic            issue;
    kill_state_t     state;
    logic [KW-1:0]   kcnt;

    assign kill  = (state == KS_KILL) || redirect;
    assign stall = dec_valid && !kill && (|hazard);
    assign issue = dec_valid && !stall && !kill;

    // A fresh issue overrides the countdown of an older producer to the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                pend[r] <= '0;
            end
        end else begin
            pend[0] <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (issue && dec_wr && (dec_dst == REG_W'(r))) begin
                    pend[r] <= dec_lat;
                end else if (pend[r] != '0) begin
                    pend[r] <= pend[r] - LW'(1);
                end
            end
        end
    end

    for (genvar k = 0; k < NSRC; k++) begin : g_port
        logic [REG_W-1:0] src;
        assign src = dec_src[k*REG_W +: REG_W];

        // Late consumers pick up the result one stage later, so they tolerate one more cycle.
        assign hazard[k] = dec_src_used[k] && (src != '0) &&
                           (pend[src] > (dec_src_late[k] ? LW'(2) : LW'(1)));

        bypass_mux #(
            .XLEN (XLEN),
            .NFWD (NFWD)
        ) u_bypass (
            .src       (src),
            .rf_val    (rf_val[k*XLEN +: XLEN]),
            .fwd_valid (fwd_valid),
            .fwd_dst   (fwd_dst),
            .fwd_data  (fwd_data),
            .opnd      (opnd[k*XLEN +: XLEN]),
            .fwd_hit   (fwd_hit[k])
        );
    end

    // The redirect cycle itself is the first kill cycle; KILL covers the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= KS_IDLE;
            kcnt  <= '0;
        end else begin
            case (state)
                KS_IDLE: begin
                    if (redirect && (KILL_CYC > 1)) begin
                        state <= KS_KILL;
                        kcnt  <= KW'(KILL_CYC - 1);
                    end
                end
                KS_KILL: begin
                    if (redirect) begin
                        kcnt <= KW'(KILL_CYC - 1);
                    end else if (kcnt <= KW'(1)) begin
                        state <= KS_IDLE;
                        kcnt  <= '0;
                    end else begin
                        kcnt <= kcnt - KW'(1);
                    end
                end
                default: begin
                    state <= KS_IDLE;
                    kcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_bypass_unit.sv
// Directed self-checking bench for hazard_bypass_unit: scoreboard stalls,
// bypass priority, kill window and asynchronous reset.
module tb_hazard_bypass_unit;

    localparam int XLEN = 32;
    localparam int NSRC = 2;
    localparam int NFWD = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 dec_valid;
    logic [NSRC*5-1:0]    dec_src;
    logic [NSRC-1:0]      dec_src_used;
    logic [NSRC-1:0]      dec_src_late;
    logic                 dec_wr;
    logic [4:0]           dec_dst;
    logic [2:0]           dec_lat;
    logic [NSRC*XLEN-1:0] rf_val;
    logic [NFWD-1:0]      fwd_valid;
    logic [NFWD*5-1:0]    fwd_dst;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 redirect;
    logic                 stall;
    logic                 kill;
    logic [NSRC*XLEN-1:0] opnd;
    logic [NSRC-1:0]      fwd_hit;

    int errors = 0;
    int checks = 0;

    hazard_bypass_unit #(
        .XLEN     (XLEN),
        .NREG     (32),
        .NSRC     (NSRC),
        .NFWD     (NFWD),
        .MAX_LAT  (4),
        .KILL_CYC (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec_valid    (dec_valid),
        .dec_src      (dec_src),
        .dec_src_used (dec_src_used),
        .dec_src_late (dec_src_late),
        .dec_wr       (dec_wr),
        .dec_dst      (dec_dst),
        .dec_lat      (dec_lat),
        .rf_val       (rf_val),
        .fwd_valid    (fwd_valid),
        .fwd_dst      (fwd_dst),
        .fwd_data     (fwd_data),
        .redirect     (redirect),
        .stall        (stall),
        .kill         (kill),
        .opnd         (opnd),
        .fwd_hit      (fwd_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        dec_valid    = 1'b0;
        dec_src      = '0;
        dec_src_used = '0;
        dec_src_late = '0;
        dec_wr       = 1'b0;
        dec_dst      = '0;
        dec_lat      = '0;
        rf_val       = '0;
        fwd_valid    = '0;
        fwd_dst      = '0;
        fwd_data     = '0;
        redirect     = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        clear_inputs();
        for (int i = 0; i < 6; i++) next_cycle();
    endtask

    task automatic issue_write(input logic [4:0] dst, input logic [2:0] lat);
        clear_inputs();
        dec_valid = 1'b1;
        dec_wr    = 1'b1;
        dec_dst   = dst;
        dec_lat   = lat;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n        = 1'b0;
        dec_valid    = 1'b1;
        dec_src[4:0] = 5'd4;
        dec_src_used = 2'b01;
        rf_val[31:0] = 32'hDEAD_0001;
        #3;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (kill !== 1'b0) begin errors++; $display("[TB] FAIL reset_kill got=%b exp=0", kill); end
        checks++; if (opnd[31:0] !== 32'hDEAD_0001) begin errors++; $display("[TB] FAIL reset_opnd got=%h exp=dead0001", opnd[31:0]); end
        checks++; if (fwd_hit !== 2'b00) begin errors++; $display("[TB] FAIL reset_hit got=%b exp=00", fwd_hit); end
        #5 rst_n = 1'b1;
        next_cycle();
        drain();
    endtask

    task automatic test_alu_chain();
        issue_write(5'd3, 3'd1);
        #3;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL alu_issue_stall got=%b exp=0", stall); end
        next_cycle();
        clear_inputs();
        dec_valid        = 1'b1;
        dec_src[4:0]     = 5'd3;
        dec_src_used     = 2'b01;
        rf_val[31:0]     = 32'h5555_5555;
        fwd_valid        = 3'b001;
        fwd_dst[4:0]     = 5'd3;
        fwd_data[31:0]   = 32'h0000_1234;
        #3;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL alu_dep_stall got=%b exp=0", stall); end
        checks++; if (opnd[31:0] !== 32'h0000_1234) begin errors++; $display("[TB] FAIL alu_opnd0 got=%h exp=00001234", opnd[31:0]); end
        checks++; if (fwd_hit[0] !== 1'b1) begin errors++; $display("[TB] FAIL alu_hit0 got=%b exp=1", fwd_hit[0]); end
        next_cycle();
        drain();
    endtask

    task automatic test_load_use();
        issue_write(5'd5, 3'd2);
        next_cycle();
        clear_inputs();
        dec_valid     = 1'b1;
        dec_src[9:5]  = 5'd5;
        dec_src_used  = 2'b10;
        rf_val[63:32] = 32'h1111_1111;
        #3;
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL load_use_bubble got=%b exp=1", stall); end
        next_cycle();
        fwd_valid       = 3'b010;
        fwd_dst[9:5]    = 5'd5;
        fwd_data[63:32] = 32'h0000_CAFE;
        #3;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL load_use_release got=%b exp=0", stall); end
        checks++; if (opnd[63:32] !== 32'h0000_CAFE) begin errors++; $display("[TB] FAIL load_use_opnd1 got=%h exp=0000cafe", opnd[63:32]); end
        checks++; if (fwd_hit[1] !== 1'b1) begin errors++; $display("[TB] FAIL load_use_hit1 got=%b exp=1", fwd_hit[1]); end
        next_cycle();
        drain();
    endtask

    task automatic test_store_late();
        issue_write(5'd5, 3'd2);
        next_cycle();
        clear_inputs();
        dec_valid    = 1'b1;
        dec_src[9:5] = 5'd5;
        dec_src_used = 2'b10;
        dec_src_late = 2'b10;
        #3;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL store_late_data got=%b exp=0", stall); end
        next_cycle();
        drain();
        issue_write(5'd5, 3'd2);
        next_cycle();
        clear_inputs();
        dec_valid    = 1'b1;
        dec_src[4:0] = 5'd5;
        dec_src_used = 2'b01;
        #3;
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL store_base_early got=%b exp=1", stall); end
        next_cycle();
        drain();
    endtask

    task automatic test_priority_r0();
        clear_inputs();
        dec_src[4:0]     = 5'd7;
        rf_val[31:0]     = 32'h0000_0077;
        fwd_valid        = 3'b101;
        fwd_dst[4:0]     = 5'd7;
        fwd_dst[14:10]   = 5'd7;
        fwd_data[31:0]   = 32'h0000_000A;
        fwd_data[95:64]  = 32'h0000_000B;
        #1;
        checks++; if (opnd[31:0] !== 32'h0000_000A) begin errors++; $display("[TB] FAIL prio_youngest got=%h exp=0000000a", opnd[31:0]); end
        fwd_valid = 3'b100;
        #1;
        checks++; if (opnd[31:0] !== 32'h0000_000B) begin errors++; $display("[TB] FAIL prio_oldest got=%h exp=0000000b", opnd[31:0]); end
        fwd_valid    = 3'b111;
        fwd_dst[4:0] = 5'd8;
        fwd_dst[9:5] = 5'd6;
        #1;
        checks++; if (opnd[31:0] !== 32'h0000_000B) begin errors++; $display("[TB] FAIL prio_dst_match got=%h exp=0000000b", opnd[31:0]); end
        fwd_dst[14:10] = 5'd9;
        #1;
        checks++; if (opnd[31:0] !== 32'h0000_0077 || fwd_hit[0] !== 1'b0) begin errors++; $display("[TB] FAIL prio_nomatch got=%h/%b exp=00000077/0", opnd[31:0], fwd_hit[0]); end
        dec_src[9:5]    = 5'd0;
        rf_val[63:32]   = 32'h0;
        fwd_valid       = 3'b001;
        fwd_dst[4:0]    = 5'd0;
        fwd_data[31:0]  = 32'h0000_00FF;
        #1;
        checks++; if (opnd[63:32] !== 32'h0) begin errors++; $display("[TB] FAIL r0_opnd got=%h exp=00000000", opnd[63:32]); end
        checks++; if (fwd_hit[1] !== 1'b0) begin errors++; $display("[TB] FAIL r0_hit got=%b exp=0", fwd_hit[1]); end
        next_cycle();
        drain();
    endtask

    task automatic test_long_redirect();
        issue_write(5'd9, 3'd4);
        next_cycle();
        clear_inputs();
        dec_valid    = 1'b1;
        dec_src[4:0] = 5'd9;
        dec_src_used = 2'b01;
        #3;
        checks++; if (stall !== 1'b1 || kill !== 1'b0) begin errors++; $display("[TB] FAIL long_stall1 got=%b/%b exp=1/0", stall, kill); end
        next_cycle();
        redirect = 1'b1;
        #3;
        checks++; if (kill !== 1'b1) begin errors++; $display("[TB] FAIL redir_kill got=%b exp=1", kill); end
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL redir_stall got=%b exp=0", stall); end
        next_cycle();
        redirect = 1'b0;
        #3;
        checks++; if (kill !== 1'b1) begin errors++; $display("[TB] FAIL kill_cyc2 got=%b exp=1", kill); end
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL kill_cyc2_stall got=%b exp=0", stall); end
        next_cycle();
        #3;
        checks++; if (kill !== 1'b0) begin errors++; $display("[TB] FAIL kill_end got=%b exp=0", kill); end
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL long_sched_clear got=%b exp=0", stall); end
        next_cycle();
        drain();
    endtask

    task automatic test_reset_mid_flight();
        issue_write(5'd9, 3'd4);
        next_cycle();
        clear_inputs();
        redirect = 1'b1;
        next_cycle();
        redirect     = 1'b0;
        dec_valid    = 1'b1;
        dec_src[4:0] = 5'd9;
        dec_src_used = 2'b01;
        #3;
        checks++; if (kill !== 1'b1) begin errors++; $display("[TB] FAIL mid_kill_active got=%b exp=1", kill); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (kill !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_kill got=%b exp=0", kill); end
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_stall got=%b exp=0", stall); end
        #2 rst_n = 1'b1;
        next_cycle();
        #3;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_r9 got=%b exp=0", stall); end
        checks++; if (kill !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_kill got=%b exp=0", kill); end
        next_cycle();
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_store_late();
        test_priority_r0();
        test_long_redirect();
        test_reset_mid_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_bypass_unit.md
Name: hazard_bypass_unit

Overview:
Parametrised successor to the pipeline's inline bypass and stall logic. It sits between decode and execute in the 5-stage MIPS pipeline. A per-register scoreboard replaces the fixed load-use check, so producers of any latency up to MAX_LAT are interlocked correctly. It muxes youngest-first forwarded data for NSRC source ports and generates a timed kill window after a branch or jump redirect.

Parameters:
XLEN, 32, datapath width
NREG, 32, architectural registers (r0 hardwired zero)
NSRC, 2, source operand ports per decoded instruction
NFWD, 3, forwarding buses (index 0 = youngest stage, X; 1 = M; 2 = W)
MAX_LAT, 4, largest producer latency in cycles
KILL_CYC, 2, decode-stage kill cycles per redirect

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
dec_valid  in  1  decode holds a real instruction
dec_src  in  NSRC*5  source register numbers
dec_src_used  in  NSRC  source is read
dec_src_late  in  NSRC  operand needed one stage late (store data)
dec_wr  in  1  instruction writes a register
dec_dst  in  5  destination register
dec_lat  in  clog2(MAX_LAT+1)  cycles from issue until result is on a fwd bus (1..MAX_LAT)
rf_val  in  NSRC*XLEN  register-file read data
fwd_valid  in  NFWD  bus carries a register result
fwd_dst  in  NFWD*5  bus destination
fwd_data  in  NFWD*XLEN  bus data
redirect  in  1  branch taken or jump resolved in X
stall  out  1  hold F/D, inject bubble into D/X
kill  out  1  discard decode-stage instruction
opnd  out  NSRC*XLEN  bypassed operands
fwd_hit  out  NSRC  operand came from a fwd bus

Behaviour:
- Reset (async, rst_n low): all pend counters = 0, kill FSM = IDLE. stall = 0, kill = 0 immediately, including when reset is asserted mid-operation. opnd passes rf_val.
- Scoreboard: pend[r] has width clog2(MAX_LAT+1).
  - Issue = dec_valid & !stall & !kill.
  - On issue with dec_wr & dec_dst != 0: pend[dec_dst] <= dec_lat.
  - Every other nonzero pend decrements by 1 each cycle, saturating at 0.
  - If issue targets a register that is also decrementing, issue wins. pend[0] is always 0.
  - Scoreboard is never cleared by kill or redirect; older producers stay in flight.
- Hazard for port k: dec_src_used[k] & src != 0 & pend[src] > (dec_src_late[k] ? 2 : 1).
- stall = dec_valid & !kill & OR(hazard_k). Combinational, same cycle.
- Latency: ALU lat 1 gives no bubble; load lat 2 gives 1 bubble; lat L gives L-1 bubbles; late operand gives one fewer bubble.
- Bypass per port, combinational:
  - src == 0 → rf_val, fwd_hit = 0.
  - Else, the lowest index i with fwd_valid[i] & fwd_dst[i] == src → fwd_data[i], fwd_hit = 1.
  - Otherwise rf_val.
- Kill FSM, states IDLE and KILL, counter kcnt:
  - In IDLE, redirect → KILL with kcnt = KILL_CYC-1.
  - In KILL, kcnt decrements; at 0 → IDLE.
  - redirect while in KILL reloads kcnt = KILL_CYC-1.
  - kill = (state == KILL) | redirect, so kill is asserted in the redirect cycle itself.
  - Kill overrides stall: stall = 0 while kill = 1.
- Simultaneous issue and redirect cannot occur, because redirect forces kill, which blocks issue.

Decomposition:
- Package pipe_pkg holds REG_W = 5, LAT_ALU = 1, LAT_LOAD = 2, LAT_DIV = MAX_LAT, and a kill-FSM state enum.
- One sub-module, bypass_mux (one port: src, rf_val, fwd buses → opnd, fwd_hit), instantiated NSRC times via generate.
- Scoreboard and kill FSM stay in the top module.

Test Plan:
- ALU chain: issue r3, lat 1; next cycle src0 = r3 with fwd0 = {1, r3, 0x1234} → stall 0, opnd0 = 0x1234, fwd_hit[0] = 1.
- Load-use: issue r5, lat 2; next instruction reads r5 on port 1 → stall = 1 for exactly 1 cycle. Then issue with fwd1 = {1, r5, 0xCAFE} → opnd1 = 0xCAFE.
- Store data late: issue r5, lat 2; next instruction reads r5 with dec_src_late[1] = 1 → stall 0. Base register r5 on port 0 with late = 0 → stall 1.
- Priority and r0:
  - fwd0 = {1, r7, 0xA} and fwd2 = {1, r7, 0xB}, src = r7 → opnd = 0xA.
  - src = r0 with fwd0 = {1, r0, 0xFF} and rf_val = 0 → opnd = 0, fwd_hit = 0.
- Long op with redirect: issue r9, lat 4; dependent instruction stalls 3 cycles. Redirect in 2nd stall cycle → kill high for 2 cycles and stall low during them. pend[r9] keeps decrementing; stall clears on schedule afterwards.
- Reset mid-flight: pend[r9] = 3 and KILL active, drop rst_n between edges → stall = 0 and kill = 0 immediately, and after release a reader of r9 does not stall.
